// File: rtl/shifter_pipelined_pkg.sv
// Shared mode encoding for the pipelined barrel shifter and its stages.
package shifter_pkg;

  localparam int SH_MODE_W = 3;

  localparam logic [SH_MODE_W-1:0] SH_LSL = 3'd0;
  localparam logic [SH_MODE_W-1:0] SH_ROL = 3'd1;
  localparam logic [SH_MODE_W-1:0] SH_LSR = 3'd2;
  localparam logic [SH_MODE_W-1:0] SH_ASR = 3'd3;
  localparam logic [SH_MODE_W-1:0] SH_ROR = 3'd4;

  function automatic logic is_legal_mode(input logic [SH_MODE_W-1:0] mode);
    return (mode <= SH_ROR);
  endfunction

endpackage

// File: rtl/shifter_pipelined_if.sv
// Operand/result handshake bundle for the pipelined shifter.
interface shifter_pipelined_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  localparam int LOG2W = $clog2(WIDTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     data_a;
  logic [LOG2W-1:0]     shift_amount;
  logic [SH_MODE_W-1:0] shift_mode;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [TAG_W-1:0]     out_tag;
  logic                 mode_error;

  modport master (
    output in_valid, data_a, shift_amount, shift_mode, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, mode_error
  );

  modport slave (
    input  in_valid, data_a, shift_amount, shift_mode, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, mode_error
  );
endinterface

// File: rtl/shifter_pipelined_stage.sv
// One binary stage of the barrel shifter: shifts or rotates by DIST when enabled.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_enable,
  input  logic [SH_MODE_W-1:0] i_mode,
  output logic [WIDTH-1:0]     o_result
);

  always_comb begin
    o_result = i_data;
    if (i_enable) begin
      case (i_mode)
        SH_LSL:  o_result = i_data << DIST;
        SH_ROL:  o_result = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
        SH_LSR:  o_result = i_data >> DIST;
        SH_ASR:  o_result = $unsigned($signed(i_data) >>> DIST);
        SH_ROR:  o_result = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        // Illegal modes pass the operand through untouched.
        default: o_result = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipelined.sv
// Runtime-mode barrel shifter with optional elastic register slots between stages.
module shifter_pipelined
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_MASK = 5'b10000,
  parameter int TAG_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  shifter_pipelined_if.slave  bus
);

  localparam int LOG2W = $clog2(WIDTH);
  // The final stage is always registered so outputs never depend on inputs.
  localparam int MASK  = REG_MASK | (1 << (LOG2W - 1));

  logic [WIDTH-1:0]     w_data  [0:LOG2W];
  logic [TAG_W-1:0]     w_tag   [0:LOG2W];
  logic                 w_err   [0:LOG2W];
  logic                 w_valid [0:LOG2W];
  logic                 w_ready [0:LOG2W];
  logic [SH_MODE_W-1:0] w_mode  [0:LOG2W-1];
  logic [LOG2W-1:0]     w_amt   [0:LOG2W-1];
  logic [WIDTH-1:0]     w_stage [0:LOG2W-1];

  assign w_data[0]      = bus.data_a;
  assign w_tag[0]       = bus.in_tag;
  assign w_err[0]       = !is_legal_mode(bus.shift_mode);
  assign w_valid[0]     = bus.in_valid;
  assign w_mode[0]      = bus.shift_mode;
  assign w_amt[0]       = bus.shift_amount;
  assign w_ready[LOG2W] = bus.out_ready;

  assign bus.in_ready   = w_ready[0];
  assign bus.out_valid  = w_valid[LOG2W];
  assign bus.result     = w_data[LOG2W];
  assign bus.out_tag    = w_tag[LOG2W];
  assign bus.mode_error = w_err[LOG2W];

  generate
    for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
      shifter_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << gi)
      ) u_stage (
        .i_data   (w_data[gi]),
        .i_enable (w_amt[gi][gi]),
        .i_mode   (w_mode[gi]),
        .o_result (w_stage[gi])
      );

      if (((MASK >> gi) & 1) != 0) begin : g_reg
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic [TAG_W-1:0] r_tag;
        logic             r_err;

        // Slot accepts when empty or when its current entry leaves this cycle.
        assign w_ready[gi] = !r_valid || w_ready[gi+1];

        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_err   <= 1'b0;
          end else if (w_ready[gi]) begin
            r_valid <= w_valid[gi];
            if (w_valid[gi]) begin
              r_data <= w_stage[gi];
              r_tag  <= w_tag[gi];
              r_err  <= w_err[gi];
            end
          end
        end

        assign w_valid[gi+1] = r_valid;
        assign w_data[gi+1]  = r_data;
        assign w_tag[gi+1]   = r_tag;
        assign w_err[gi+1]   = r_err;

        if (gi < LOG2W - 1) begin : g_fwd
          logic [SH_MODE_W-1:0] r_mode;
          logic [LOG2W-1:0]     r_amt;

          always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
              r_mode <= '0;
              r_amt  <= '0;
            end else if (w_ready[gi] && w_valid[gi]) begin
              r_mode <= w_mode[gi];
              r_amt  <= w_amt[gi];
            end
          end

          assign w_mode[gi+1] = r_mode;
          assign w_amt[gi+1]  = r_amt;
        end
      end else begin : g_comb
        assign w_ready[gi]   = w_ready[gi+1];
        assign w_valid[gi+1] = w_valid[gi];
        assign w_data[gi+1]  = w_stage[gi];
        assign w_tag[gi+1]   = w_tag[gi];
        assign w_err[gi+1]   = w_err[gi];

        if (gi < LOG2W - 1) begin : g_fwd
          assign w_mode[gi+1] = w_mode[gi];
          assign w_amt[gi+1]  = w_amt[gi];
        end
      end
    end
  endgenerate

endmodule
